// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// Data accesses win by default; a starvation counter forces fetch progress.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ack,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    output logic                m_req,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ready,
    output logic                busy
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [2:0] {
        IDLE,
        GNT_I,
        GNT_D,
        DONE_I,
        DONE_D
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       grant_i;
    logic       grant_d;
    logic [3:0] starve_cnt;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= STARVE_LIM) ? STARVE_LIM : v + 4'd1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration happens only in IDLE; requests are ignored elsewhere.
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && (!if_req || (starve_cnt < STARVE_LIM))) begin
                    grant_d   = 1'b1;
                    state_nxt = GNT_D;
                end else if (if_req) begin
                    grant_i   = 1'b1;
                    state_nxt = GNT_I;
                end
            end
            GNT_I:   if (m_ready) state_nxt = DONE_I;
            GNT_D:   if (m_ready) state_nxt = DONE_D;
            DONE_I:  state_nxt = IDLE;
            DONE_D:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= 4'd0;
        end else if (grant_i) begin
            starve_cnt <= 4'd0;
        end else if (grant_d && if_req) begin
            starve_cnt <= sat_inc(starve_cnt);
        end
    end

    // Memory command is captured on grant and held until m_ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_addr   <= '0;
            m_we     <= 1'b0;
            m_be     <= '0;
            m_wdata  <= '0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            if (grant_d) begin
                m_addr  <= d_addr;
                m_we    <= d_we;
                m_be    <= d_be;
                m_wdata <= d_wdata;
            end else if (grant_i) begin
                m_addr <= {if_addr[ADDR_W-1:2], 2'b00};
                m_we   <= 1'b0;
                m_be   <= '1;
            end
            if ((state == GNT_D) && m_ready && !m_we) begin
                d_rdata <= m_rdata;
            end
            if ((state == GNT_I) && m_ready) begin
                if_rdata <= m_rdata;
            end
        end
    end

    assign m_req  = (state == GNT_I) || (state == GNT_D);
    assign if_ack = (state == DONE_I);
    assign d_ack  = (state == DONE_D);
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a behavioural memory plus scoreboards for
// the memory command stream and both read-data ports.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        m_req;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = 32'h0;
    logic        m_ready = 1'b0;
    logic        busy;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        fetch;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_starve;
        logic [3:0]  starve;
    } acc_t;

    typedef struct {
        logic        store;
        logic [31:0] val;
    } rd_t;

    acc_t        acc_q[$];
    logic [31:0] if_q[$];
    rd_t         d_q[$];
    logic [31:0] mem [logic [31:0]];
    int          wait_cfg = 0;
    int          wait_left = 0;
    logic        in_access = 1'b0;
    logic [31:0] if_hold = 32'h0;
    logic [31:0] d_hold = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory model and output scoreboards, evaluated away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if_hold   = 32'h0;
            d_hold    = 32'h0;
            in_access = 1'b0;
            m_ready   = 1'b0;
        end else begin
            if (m_req) begin
                if (!in_access) begin
                    in_access = 1'b1;
                    wait_left = wait_cfg;
                end
                if (acc_q.size() == 0) begin
                    chk("m_req_spurious", 32'(m_req), 32'd0);
                    m_ready = 1'b0;
                end else begin
                    chk("m_addr", m_addr, acc_q[0].addr);
                    chk("m_we", 32'(m_we), 32'(acc_q[0].we));
                    chk("m_be", 32'(m_be), 32'(acc_q[0].be));
                    if (acc_q[0].we) chk("m_wdata", m_wdata, acc_q[0].wdata);
                    if (acc_q[0].chk_starve)
                        chk("starve_cnt", 32'(dut.starve_cnt), 32'(acc_q[0].starve));
                    if (wait_left == 0) begin
                        m_ready   = 1'b1;
                        m_rdata   = acc_q[0].we ? 32'hBAD0_BAD0 : mem_rd(acc_q[0].addr);
                        in_access = 1'b0;
                        void'(acc_q.pop_front());
                    end else begin
                        m_ready = 1'b0;
                        m_rdata = $urandom;
                        wait_left--;
                    end
                end
            end else begin
                m_ready   = 1'b0;
                m_rdata   = $urandom;
                in_access = 1'b0;
            end

            if (if_ack) begin
                if (if_q.size() == 0) begin
                    chk("if_ack_spurious", 32'(if_ack), 32'd0);
                end else begin
                    if_hold = if_q.pop_front();
                    chk("if_rdata", if_rdata, if_hold);
                end
            end else begin
                chk("if_rdata_hold", if_rdata, if_hold);
            end

            if (d_ack) begin
                if (d_q.size() == 0) begin
                    chk("d_ack_spurious", 32'(d_ack), 32'd0);
                end else begin
                    if (!d_q[0].store) d_hold = d_q[0].val;
                    void'(d_q.pop_front());
                    chk("d_rdata", d_rdata, d_hold);
                end
            end else begin
                chk("d_rdata_hold", d_rdata, d_hold);
            end
        end
    end

    task automatic fetch(input logic [31:0] addr, output int ack_cyc);
        int n = 0;
        if_addr = addr;
        if_req  = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!if_ack && n < 200);
        chk("if_ack_timeout", 32'(if_ack), 32'd1);
        ack_cyc = cyc;
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic data(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, output int ack_cyc);
        int n = 0;
        d_we    = we;
        d_be    = be;
        d_addr  = addr;
        d_wdata = wdata;
        d_req   = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!d_ack && n < 200);
        chk("d_ack_timeout", 32'(d_ack), 32'd1);
        ack_cyc = cyc;
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_m_req"}, 32'(m_req), 32'd0);
        chk({tag, "_m_we"}, 32'(m_we), 32'd0);
        chk({tag, "_if_ack"}, 32'(if_ack), 32'd0);
        chk({tag, "_d_ack"}, 32'(d_ack), 32'd0);
        chk({tag, "_m_be"}, 32'(m_be), 32'd0);
        chk({tag, "_m_addr"}, m_addr, 32'd0);
        chk({tag, "_m_wdata"}, m_wdata, 32'd0);
        chk({tag, "_if_rdata"}, if_rdata, 32'd0);
        chk({tag, "_d_rdata"}, d_rdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t0, ta, tb, tc, td, xd, xi0, xi1;
        rst = 1'b0; if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
        #1;
        chk_quiet("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // Fetch only, zero wait, unaligned address
        mem[32'h4] = 32'h13;
        acc_q.push_back('{1'b1, 32'h4, 1'b0, 4'hF, 32'h0, 1'b1, 4'd0});
        if_q.push_back(32'h13);
        t0 = cyc;
        fetch(32'h6, ta);
        chk("fetch_latency", 32'(ta - t0), 32'd2);

        // Store with three wait states
        wait_cfg = 3;
        acc_q.push_back('{1'b0, 32'h100, 1'b1, 4'b0011, 32'hDEAD_BEEF, 1'b1, 4'd0});
        d_q.push_back('{1'b1, 32'h0});
        t0 = cyc;
        data(1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF, ta);
        chk("store_latency", 32'(ta - t0), 32'd5);
        wait_cfg = 0;

        // Contention: eight loads against two fetches
        for (int k = 0; k < 10; k++) begin
            if (k == 4 || k == 9) begin
                acc_q.push_back('{1'b1, (k == 4) ? 32'h40 : 32'h44, 1'b0, 4'hF, 32'h0, 1'b1, 4'd0});
            end else begin
                int j;
                j = (k < 4) ? k : k - 1;
                acc_q.push_back('{1'b0, 32'h300 + 32'(4 * j), 1'b0, 4'hF, 32'h0, 1'b1,
                                  (k < 4) ? 4'(k + 1) : 4'(k - 4)});
                d_q.push_back('{1'b0, mem_rd(32'h300 + 32'(4 * j))});
            end
        end
        if_q.push_back(mem_rd(32'h40));
        if_q.push_back(mem_rd(32'h44));
        fork
            begin
                for (int k = 0; k < 8; k++) data(1'b0, 4'hF, 32'h300 + 32'(4 * k), 32'h0, xd);
            end
            begin
                fetch(32'h40, xi0);
                fetch(32'h44, xi1);
            end
        join
        chk("contention_last_fetch_after_loads", 32'(xi1 > xd), 32'd1);
        chk("contention_first_fetch", 32'(xi0 < xd), 32'd1);

        // Load and fetch requested together: load completes first
        mem[32'h200] = 32'h11;
        mem[32'h0]   = 32'h22;
        acc_q.push_back('{1'b0, 32'h200, 1'b0, 4'hF, 32'h0, 1'b1, 4'd1});
        acc_q.push_back('{1'b1, 32'h0, 1'b0, 4'hF, 32'h0, 1'b1, 4'd0});
        d_q.push_back('{1'b0, 32'h11});
        if_q.push_back(32'h22);
        fork
            data(1'b0, 4'hF, 32'h200, 32'h0, td);
            fetch(32'h0, tb);
        join
        chk("load_before_fetch", 32'(td < tb), 32'd1);

        // Back-to-back fetches, zero wait
        for (int k = 0; k < 3; k++) begin
            acc_q.push_back('{1'b1, 32'(4 * k), 1'b0, 4'hF, 32'h0, 1'b0, 4'd0});
            if_q.push_back(mem_rd(32'(4 * k)));
        end
        fetch(32'h0, ta);
        fetch(32'h4, tb);
        fetch(32'h8, tc);
        chk("b2b_gap_1", 32'(tb - ta), 32'd3);
        chk("b2b_gap_2", 32'(tc - tb), 32'd3);

        // Reset in the middle of a stalled load
        wait_cfg = 20;
        acc_q.push_back('{1'b0, 32'h500, 1'b0, 4'hF, 32'h0, 1'b0, 4'd0});
        d_we = 1'b0; d_be = 4'hF; d_addr = 32'h500; d_wdata = 32'h0; d_req = 1'b1;
        begin
            int n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!m_req && n < 50);
        end
        chk("rst_mid_gnt", 32'(m_req), 32'd1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk_quiet("rst_mid");
        d_req = 1'b0;
        acc_q.delete();
        wait_cfg = 0;
        @(posedge clk);
        #3 rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk_quiet("post_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer that shares one single-ported unified memory between the CPU's instruction-fetch port and its load/store port. It sits between the `cpu` datapath and the memory, so the single-cycle datapath can evolve into a multi-cycle or pipelined core with one memory. Requesters use a req/ack handshake; the memory side uses req/ready with arbitrary wait states. Data accesses win by default, and a starvation counter guarantees fetch progress.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte enables are DATA_W/8 bits)
- STARVE_MAX, 4, consecutive data grants with fetch pending before fetch is forced; range 1..15
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word; valid while if_ack=1, then held
- if_ack  out  1  one-cycle completion pulse
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store
- d_be  in  DATA_W/8  store byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data; valid while d_ack=1, then held
- d_ack  out  1  one-cycle completion pulse, for loads and stores
- m_req  out  1  memory request
- m_we  out  1  memory write strobe
- m_be  out  DATA_W/8  memory byte enables
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data; sampled when m_ready=1
- m_ready  in  1  memory completes the current access this cycle
- busy  out  1  state is not IDLE

## Operation
- FSM states: IDLE, GNT_I, GNT_D, DONE_I, DONE_D.
- **IDLE**, decision at the clock edge:
  - only d_req → GNT_D
  - only if_req → GNT_I
  - both high and starve_cnt < STARVE_MAX → GNT_D
  - both high and starve_cnt = STARVE_MAX → GNT_I
  - neither → stay in IDLE
- **Capture on entry:**
  - GNT_D registers m_addr=d_addr, m_we=d_we, m_be=d_be, m_wdata=d_wdata.
  - GNT_I registers m_addr={if_addr[ADDR_W-1:2],2'b00}, m_we=0, m_be=all ones; m_wdata keeps its previous value.
- **GNT_x:** m_req=1. All m_* are held stable until m_ready=1; that edge moves to DONE_x. GNT_D also latches m_rdata into d_rdata, but only if m_we=0. GNT_I latches m_rdata into if_rdata.
- **DONE_x:** x_ack=1 for exactly this cycle, m_req=0, then → IDLE unconditionally.
- **Requester rules:** the requester updates or drops req on the edge that ends its ack cycle. IDLE therefore always sees fresh requests. Request inputs are ignored outside IDLE.
- **starve_cnt:** width 4, reset 0.
  - Increments on entry to GNT_D while if_req=1, saturating at STARVE_MAX.
  - Clears on entry to GNT_I.
  - Unchanged on entry to GNT_D while if_req=0.
- **Reset** (asynchronous, active-low; effective immediately, including mid-transaction): state=IDLE; m_req, m_we, if_ack, d_ack and busy all 0; m_be, m_addr, m_wdata, if_rdata, d_rdata and starve_cnt all 0. An in-flight access is abandoned with no ack, and the memory must tolerate a dropped m_req.
- All outputs are registered or decoded from state only. There is no combinational path from m_ready to any output.

## Timing
- Zero-wait memory (m_ready=1 in the first GNT cycle): req seen at edge E → GNT in cycle E+1 → ack in cycle E+2 → IDLE in E+3. This gives 3 cycles per access and at most one access per 3 cycles.
- Each memory wait cycle adds exactly one cycle of latency.
- Back-to-back: a requester that re-asserts req in the cycle after its ack gets its next GNT one cycle later.
- x_rdata changes only on the m_ready edge of its own port's transaction.

## Test plan
- **Fetch-only, zero wait:** if_req=1, if_addr=0x0000_0006, memory returns 0x0000_0013. Required: m_addr=0x0000_0004, m_we=0, m_be=4'hF; if_ack pulses 2 cycles after if_req is sampled, with if_rdata=0x0000_0013.
- **Store with wait states:** d_req=1, d_we=1, d_be=4'b0011, d_addr=0x100, d_wdata=0xDEADBEEF, m_ready low for 3 cycles. Required: all m_* stable across the 4 GNT_D cycles; d_ack exactly one cycle; d_rdata unchanged.
- **Contention and starvation, STARVE_MAX=4:** if_req and d_req held high continuously. Required grant order D,D,D,D,I,D,D,D,D,I; starve_cnt reaches 4 and then clears.
- **Load vs. fetch ordering:** d_req (load 0x200 → 0x11) and if_req (0x0 → 0x22) both set. Required: d_ack with d_rdata=0x11 occurs before if_ack with if_rdata=0x22; if_rdata does not change during the load.
- **Reset mid-access:** assert rst=0 during GNT_D while m_ready=0. Required: m_req=0 and busy=0 before the next edge; no ack; after release with no requests, the block stays in IDLE with all outputs 0.
- **Back-to-back fetch:** hold if_req=1 with addresses 0x0, 0x4, 0x8 advanced on each ack, zero-wait memory. Required: acks spaced exactly 3 cycles apart.
